// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C subordinate: FSM state encoding,
// address/byte widths and a small majority-vote helper used by the
// optional line filter.
package i2c_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 3;

  // Bit counter value seen on the last bit of a byte (counter wraps after it)
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_sub_state_t;

  // Two-out-of-three vote used to reject single-sample glitches
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA conditioning for the I2C subordinate: two-flop synchronizers,
// an optional 3-sample majority filter (enabled by defining
// I2C_SUB_GLITCH_FILTER_EN) and SCL edge / START / STOP detection.
// Pin-to-detect latency is 3 clk without the filter and 5 clk with it.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_p0, scl_p1;
  logic sda_p0, sda_p1;
  logic scl;
  logic scl_q, sda_q;

  // Two-flop synchronizers; the bus idles high so reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      // stage p0 -> p1
      scl_p0 <= scl_in;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
    end
  end

`ifdef I2C_SUB_GLITCH_FILTER_EN
  logic [1:0] scl_hist_p2, sda_hist_p2;
  logic       scl_flt_p3, sda_flt_p3;

  // Majority vote over the last three synchronized samples, registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_p2 <= 2'b11;
      sda_hist_p2 <= 2'b11;
      scl_flt_p3  <= 1'b1;
      sda_flt_p3  <= 1'b1;
    end else begin
      // stage p1 -> p2 history, p2 -> p3 vote
      scl_hist_p2 <= {scl_hist_p2[0], scl_p1};
      sda_hist_p2 <= {sda_hist_p2[0], sda_p1};
      scl_flt_p3  <= maj3(scl_p1, scl_hist_p2[0], scl_hist_p2[1]);
      sda_flt_p3  <= maj3(sda_p1, sda_hist_p2[0], sda_hist_p2[1]);
    end
  end

  assign scl = scl_flt_p3;
  assign sda = sda_flt_p3;
`else
  assign scl = scl_p1;
  assign sda = sda_p1;
`endif

  // Previous conditioned levels for edge and bus-condition detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  // START/STOP need SCL high on both samples so an SDA change that
  // coincides with an SCL edge is never misread as a bus condition.
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_subordinate.sv
// I2C subordinate (target) with 7-bit address, byte write and byte read.
// SDA is sampled on detected SCL rise and its open-drain drive only ever
// changes on detected SCL fall. Defining I2C_SUB_GLITCH_FILTER_EN adds a
// 3-sample majority filter on SCL/SDA inside i2c_line_sync.
module i2c_subordinate
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCL,
  inout  wire               SDA,
  input  logic [ADDR_W-1:0] own_addr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              nack_rx,
  output logic [2:0]        state_out
);

  i2c_sub_state_t       state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_W-2:0]    shreg;
  logic [DATA_W-1:0]    tx_shift;
  logic                 rw;
  logic                 ack_ph;
  logic                 sda_oe;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (SCL),
    .sda_in   (SDA),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

  // Open-drain: pull low or float, never drive high
  assign SDA       = sda_oe ? 1'b0 : 1'bz;
  assign state_out = state;

  // Protocol FSM with registered SDA enable and status pulses.
  // ack_ph marks the second half of an ACK phase: in ADDR_ACK/RX_ACK it
  // means "ACK is being driven", in TX_ACK it means "master ACKed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_shift <= '0;
      rw       <= 1'b0;
      ack_ph   <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      done     <= 1'b0;
      nack_rx  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      done     <= 1'b0;
      nack_rx  <= 1'b0;

      if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        ack_ph <= 1'b0;
        done   <= busy;
        busy   <= 1'b0;
      end else if (start_det) begin
        // Repeated START behaves exactly like a first START
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_ph  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[DATA_W-3:0], sda_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                // shreg now holds the 7 address bits, sda_s is R/W.
                // Address 0 only matches when own_addr is also 0.
                if (shreg == own_addr) begin
                  state  <= ST_ADDR_ACK;
                  rw     <= sda_s;
                  ack_ph <= 1'b0;
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe <= 1'b1;
                ack_ph <= 1'b1;
                busy   <= 1'b1;
              end else begin
                ack_ph <= 1'b0;
                if (rw) begin
                  // This fall opens the first read bit: consume tx_data now
                  state    <= ST_TX;
                  tx_req   <= 1'b1;
                  sda_oe   <= ~tx_data[DATA_W-1];
                  tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                end else begin
                  state  <= ST_RX;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          ST_RX: begin
            if (scl_rise) begin
              shreg   <= {shreg[DATA_W-3:0], sda_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= {shreg, sda_s};
                rx_valid <= 1'b1;
                state    <= ST_RX_ACK;
                ack_ph   <= 1'b0;
              end
            end
          end

          ST_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe <= 1'b1;
                ack_ph <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ack_ph <= 1'b0;
                state  <= ST_RX;
              end
            end
          end

          ST_TX: begin
            // Counter wraps to 0 on the 8th rise; the fall after it ends the byte
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == '0) begin
                sda_oe <= 1'b0;
                state  <= ST_TX_ACK;
                ack_ph <= 1'b0;
              end else begin
                sda_oe   <= ~tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              end
            end
          end

          ST_TX_ACK: begin
            if (scl_rise && !ack_ph) begin
              if (!sda_s) begin
                ack_ph <= 1'b1;
              end else begin
                nack_rx <= 1'b1;
                state   <= ST_IGNORE;
              end
            end else if (scl_fall && ack_ph) begin
              ack_ph   <= 1'b0;
              state    <= ST_TX;
              tx_req   <= 1'b1;
              sda_oe   <= ~tx_data[DATA_W-1];
              tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
            end
          end

          ST_IDLE, ST_IGNORE: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_subordinate.sv
// Directed testbench for i2c_subordinate. A bit-banged master drives the
// bus; expected DUT status pulses are queued as the stimulus is issued and
// a separate monitor pops and compares them as the pulses appear.
module tb_i2c_subordinate;

  localparam int Q = 5;  // clk cycles per quarter SCL period
`ifdef I2C_SUB_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  localparam int EV_RX   = 0;
  localparam int EV_TX   = 1;
  localparam int EV_NACK = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SCL = 1'b1;
  wire        SDA;
  logic       m_oe = 1'b0;
  logic [6:0] own_addr = 7'h01;
  logic [7:0] tx_data;
  logic [7:0] tx_a = 8'hA5;
  logic [7:0] tx_b = 8'h3C;
  int         tx_cnt = 0;
  int         tx_base = 0;
  logic       tx_req, rx_valid, busy, done, nack_rx;
  logic [7:0] rx_data;
  logic [2:0] state_out;

  int  n_vec = 0;
  int  n_err = 0;
  ev_t exp_q[$];

  assign SDA = m_oe ? 1'b0 : 1'bz;
  pullup (SDA);

  // First byte of a read comes from tx_a, every later one from tx_b
  assign tx_data = (tx_cnt == tx_base) ? tx_a : tx_b;

  i2c_subordinate dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SCL       (SCL),
    .SDA       (SDA),
    .own_addr  (own_addr),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .done      (done),
    .nack_rx   (nack_rx),
    .state_out (state_out)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: got event %0d data %0h, required no event", kind, d);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_data", d, e.data);
    end
  endtask

  // Monitor: compare every status pulse against the head of the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) sb_pop(EV_RX, rx_data);
      if (tx_req) begin
        sb_pop(EV_TX, tx_data);
        tx_cnt = tx_cnt + 1;
      end
      if (nack_rx) sb_pop(EV_NACK, 8'h00);
      if (done) sb_pop(EV_DONE, 8'h00);
    end
  end

  task automatic q_delay();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_oe = 1'b0; q_delay();
    SCL = 1'b1;  q_delay();
    m_oe = 1'b1; q_delay();
    SCL = 1'b0;  q_delay();
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; q_delay();
    SCL = 1'b1;  q_delay();
    m_oe = 1'b0; q_delay();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_oe = ~b;  q_delay();
    SCL = 1'b1; q_delay();
    s = SDA;    q_delay();
    SCL = 1'b0; q_delay();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_out, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
    bus_bit(ack_out, s);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #(10 * 80000);
    n_err++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda", SDA, 1'b1);
    check("rst_state", state_out, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {tx_req, rx_valid, done, nack_rx}, 4'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Write 0x81 to address 0x01, START timed for detect latency
    expect_ev(EV_RX, 8'h81);
    expect_ev(EV_DONE, 8'h00);
    @(posedge clk);
    #1;
    m_oe = 1'b1;
    repeat (LAT) @(negedge clk);
    check("start_latency_early", state_out, 3'd0);
    @(negedge clk);
    check("start_latency", state_out, 3'd1);
    #1;
    q_delay();
    SCL = 1'b0;
    q_delay();
    write_byte(8'h02, ack);
    check("wr_addr_ack", ack, 1'b0);
    check("wr_busy", busy, 1'b1);
    write_byte(8'h81, ack);
    check("wr_data_ack", ack, 1'b0);
    bus_stop();
    repeat (4) @(posedge clk);
    #1;
    check("wr_rx_data", rx_data, 8'h81);
    check("wr_idle", state_out, 3'd0);
    check_drained("wr_drained");

    // Read two bytes, ACK then NACK
    tx_base = tx_cnt;
    tx_a = 8'hA5;
    tx_b = 8'h3C;
    expect_ev(EV_TX, 8'hA5);
    expect_ev(EV_TX, 8'h3C);
    expect_ev(EV_NACK, 8'h00);
    expect_ev(EV_DONE, 8'h00);
    bus_start();
    write_byte(8'h03, ack);
    check("rd_addr_ack", ack, 1'b0);
    read_byte(1'b0, d);
    check("rd_byte0", d, 8'hA5);
    read_byte(1'b1, d);
    check("rd_byte1", d, 8'h3C);
    check("rd_nack_state", state_out, 3'd7);
    bus_stop();
    repeat (4) @(posedge clk);
    #1;
    check_drained("rd_drained");

    // Foreign address 0x22: never driven, never busy
    bus_start();
    write_byte(8'h44, ack);
    check("ign_addr_nack", ack, 1'b1);
    check("ign_state", state_out, 3'd7);
    check("ign_busy", busy, 1'b0);
    read_byte(1'b1, d);
    check("ign_bus_free", d, 8'hFF);
    check("ign_state2", state_out, 3'd7);
    check("ign_busy2", busy, 1'b0);
    bus_stop();
    repeat (4) @(posedge clk);
    #1;
    check("ign_idle", state_out, 3'd0);
    check_drained("ign_drained");

    // Write 0x10, repeated START, read one byte
    expect_ev(EV_RX, 8'h10);
    bus_start();
    write_byte(8'h02, ack);
    check("rs_addr_ack", ack, 1'b0);
    write_byte(8'h10, ack);
    check("rs_data_ack", ack, 1'b0);
    check("rs_busy", busy, 1'b1);
    bus_start();
    check("rs_state_addr", state_out, 3'd1);
    check("rs_busy_drop", busy, 1'b0);
    check_drained("rs_no_done");
    tx_base = tx_cnt;
    tx_a = 8'h5A;
    tx_b = 8'h5A;
    expect_ev(EV_TX, 8'h5A);
    expect_ev(EV_NACK, 8'h00);
    expect_ev(EV_DONE, 8'h00);
    write_byte(8'h03, ack);
    check("rs_rd_ack", ack, 1'b0);
    read_byte(1'b1, d);
    check("rs_rd_byte", d, 8'h5A);
    bus_stop();
    repeat (4) @(posedge clk);
    #1;
    check_drained("rs_drained");

    // Reset during the 4th bit of a read while the DUT pulls SDA low
    tx_base = tx_cnt;
    tx_a = 8'h00;
    tx_b = 8'h00;
    expect_ev(EV_TX, 8'h00);
    bus_start();
    write_byte(8'h03, ack);
    check("rst_rd_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
    m_oe = 1'b0;
    q_delay();
    check("rst_bit4_driven", SDA, 1'b0);
    SCL = 1'b1;
    q_delay();
    rst_n = 1'b0;
    #1;
    check("midrst_sda", SDA, 1'b1);
    check("midrst_state", state_out, 3'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_pulses", {tx_req, rx_valid, done, nack_rx}, 4'h0);
    check_drained("midrst_drained");
    q_delay();
    rst_n = 1'b1;
    SCL = 1'b0;
    q_delay();
    bus_bit(1'b1, s);
    check("postrst_wait", state_out, 3'd0);
    bus_stop();
    repeat (4) @(posedge clk);
    #1;
    check("postrst_idle", state_out, 3'd0);
    check_drained("postrst_drained");

`ifdef I2C_SUB_GLITCH_FILTER_EN
    // One-clk SDA low pulse with SCL high must not look like START
    @(posedge clk);
    #1;
    m_oe = 1'b1;
    @(posedge clk);
    #1;
    m_oe = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_no_start", state_out, 3'd0);
`endif

    check_drained("final_drained");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
